demux_scan_sequencer: RTL

- Upstream driver for the 1-to-8 demultiplexer; generates its data input `I` and 3-bit select `S`.
- On a start pulse it sweeps the select through channels 0..7, holding each channel for a programmable dwell, and routes a registered copy of serial data `D` onto `I`.
- Supports single-sweep and continuous modes, with a start/busy/done handshake to the controlling logic.

---
 rtl/demux_scan_sequencer_if.sv | 35 +++
 rtl/demux_scan_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/demux_scan_sequencer_if.sv
// Handshake and data bundle between the scan controller and demux_scan_sequencer.
// MASK exists only when SEQ_CH_MASK_EN is defined.
interface demux_scan_sequencer_if #(
   parameter int DWELL_W = 8
);
   logic               START;
   logic               STOP;
   logic               MODE;
   logic [DWELL_W-1:0] DWELL;
   logic               D;
`ifdef SEQ_CH_MASK_EN
   logic [7:0]         MASK;
`endif
   logic               I;
   logic [2:0]         S;
   logic               BUSY;
   logic               DONE;
   logic               CH_STB;

   modport master (
`ifdef SEQ_CH_MASK_EN
      output MASK,
`endif
      output START, STOP, MODE, DWELL, D,
      input  I, S, BUSY, DONE, CH_STB
   );

   modport slave (
`ifdef SEQ_CH_MASK_EN
      input  MASK,
`endif
      input  START, STOP, MODE, DWELL, D,
      output I, S, BUSY, DONE, CH_STB
   );
endinterface

// File: rtl/demux_scan_sequencer.sv
// Sweeps the 1-to-8 demux select through its channels with a programmable dwell,
// routing registered serial data onto I. Optional channel mask: SEQ_CH_MASK_EN.
module demux_scan_sequencer #(
   parameter int DWELL_W = 8
) (
   input logic                   CLK,
   input logic                   RST,
   demux_scan_sequencer_if.slave bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic [2:0]         sel_q;
   logic               data_q;
   logic               busy_q;
   logic               done_q;
   logic               stb_q;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [DWELL_W-1:0] dwell_lat;
   logic [7:0]         start_mask;
   logic [7:0]         run_mask;
   logic [3:0]         first_hit;
   logic [3:0]         next_hit;
   logic [3:0]         wrap_hit;
   logic               last_cycle;

   // Returns {found, channel}: lowest enabled channel at or above 'from'.
   function automatic logic [3:0] find_ch(input logic [7:0] m, input logic [3:0] from);
      logic [3:0] r;
      r = 4'd0;
      for (int c = 7; c >= 0; c--) begin
         if (m[c] && (4'(c) >= from)) r = {1'b1, 3'(c)};
      end
      return r;
   endfunction

`ifdef SEQ_CH_MASK_EN
   logic [7:0] mask_lat;
   assign start_mask = bus.MASK;
   assign run_mask   = mask_lat;
`else
   assign start_mask = 8'hFF;
   assign run_mask   = 8'hFF;
`endif

   assign first_hit  = find_ch(start_mask, 4'd0);
   assign next_hit   = find_ch(run_mask, {1'b0, sel_q} + 4'd1);
   assign wrap_hit   = find_ch(run_mask, 4'd0);
   assign last_cycle = (dwell_cnt == dwell_lat - DWELL_W'(1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         sel_q     <= 3'd0;
         data_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         stb_q     <= 1'b0;
         dwell_cnt <= '0;
         dwell_lat <= '0;
`ifdef SEQ_CH_MASK_EN
         mask_lat  <= 8'd0;
`endif
      end else begin
         done_q <= 1'b0;
         stb_q  <= 1'b0;
         case (state)
            IDLE: begin
               sel_q  <= 3'd0;
               data_q <= 1'b0;
               if (bus.START && !bus.STOP && first_hit[3]) begin
                  state     <= RUN;
                  busy_q    <= 1'b1;
                  sel_q     <= first_hit[2:0];
                  stb_q     <= 1'b1;
                  data_q    <= bus.D;
                  dwell_cnt <= '0;
                  dwell_lat <= (bus.DWELL == '0) ? DWELL_W'(1) : bus.DWELL;
`ifdef SEQ_CH_MASK_EN
                  mask_lat  <= bus.MASK;
`endif
               end
            end
            RUN: begin
               if (bus.STOP) begin
                  state     <= IDLE;
                  busy_q    <= 1'b0;
                  sel_q     <= 3'd0;
                  data_q    <= 1'b0;
                  dwell_cnt <= '0;
               end else if (!last_cycle) begin
                  dwell_cnt <= dwell_cnt + DWELL_W'(1);
                  data_q    <= bus.D;
               end else if (next_hit[3] || bus.MODE) begin
                  // Advance within the sweep, or wrap to the lowest enabled channel.
                  sel_q     <= next_hit[3] ? next_hit[2:0] : wrap_hit[2:0];
                  dwell_cnt <= '0;
                  stb_q     <= 1'b1;
                  data_q    <= bus.D;
               end else begin
                  state     <= IDLE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  sel_q     <= 3'd0;
                  data_q    <= 1'b0;
                  dwell_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.S      = sel_q;
   assign bus.I      = data_q;
   assign bus.BUSY   = busy_q;
   assign bus.DONE   = done_q;
   assign bus.CH_STB = stb_q;

endmodule
